// File: rtl/dnn_result_pkg.sv
// Shared types and defaults for the DNN result/argmax output stage.
package dnn_result_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 7;
  localparam int unsigned DEF_NUM_CLASSES = 10;
  localparam int unsigned DEF_MARGIN_THR  = 4;

  // Index width needed to address n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_IDX_WIDTH = idx_width(DEF_NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [DEF_DATA_WIDTH-1:0] score_t;

  localparam score_t SCORE_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/dnn_argmax_step.sv
// One signed argmax update: folds score s into the running best/second pair.
module dnn_argmax_step #(
  parameter int unsigned DATA_WIDTH = 7,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic signed [DATA_WIDTH-1:0] best_i,
  input  logic signed [DATA_WIDTH-1:0] second_i,
  input  logic        [IDX_WIDTH-1:0]  best_idx_i,
  input  logic signed [DATA_WIDTH-1:0] s_i,
  input  logic        [IDX_WIDTH-1:0]  ptr_i,
  output logic signed [DATA_WIDTH-1:0] best_nxt_c,
  output logic signed [DATA_WIDTH-1:0] second_nxt_c,
  output logic        [IDX_WIDTH-1:0]  best_idx_nxt_c
);

  // Strict compare on best keeps the lowest index on ties; ties still lift second.
  always_comb begin
    best_nxt_c     = best_i;
    second_nxt_c   = second_i;
    best_idx_nxt_c = best_idx_i;
    if (s_i > best_i) begin
      second_nxt_c   = best_i;
      best_nxt_c     = s_i;
      best_idx_nxt_c = ptr_i;
    end else if (s_i > second_i) begin
      second_nxt_c = s_i;
    end
  end

endmodule

// File: rtl/dnn_result_unit.sv
// Output stage: snapshots class scores, runs a sequential argmax scan and
// provides a registered indexed read port into the snapshot.
module dnn_result_unit
  import dnn_result_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int unsigned IDX_WIDTH   = idx_width(NUM_CLASSES),
  parameter int unsigned MARGIN_THR  = DEF_MARGIN_THR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] scores_in [NUM_CLASSES],
  input  logic                         rd_en,
  input  logic        [IDX_WIDTH-1:0]  rd_idx,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         rd_err,
  output logic                         busy,
  output logic                         result_valid,
  output logic        [IDX_WIDTH-1:0]  class_idx,
  output logic signed [DATA_WIDTH-1:0] class_score,
  output logic        [DATA_WIDTH-1:0] margin,
  output logic                         low_conf
);

  localparam logic        [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic        [DATA_WIDTH-1:0] THR       = DATA_WIDTH'(MARGIN_THR);

  state_t state_q, state_d;
  logic signed [DATA_WIDTH-1:0] snap_q [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] snap_d [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best_q, best_d, second_q, second_d;
  logic        [IDX_WIDTH-1:0]  best_idx_q, best_idx_d, ptr_q, ptr_d;
  logic signed [DATA_WIDTH-1:0] rd_data_q, rd_data_d, class_score_q, class_score_d;
  logic                         rd_err_q, rd_err_d, busy_q, busy_d;
  logic                         valid_q, valid_d, low_conf_q, low_conf_d;
  logic        [IDX_WIDTH-1:0]  class_idx_q, class_idx_d;
  logic        [DATA_WIDTH-1:0] margin_q, margin_d;

  logic signed [DATA_WIDTH-1:0] scan_s_c, step_best_c, step_second_c;
  logic        [IDX_WIDTH-1:0]  step_idx_c;
  logic        [DATA_WIDTH-1:0] margin_c;

  assign scan_s_c = snap_q[ptr_q];

  dnn_argmax_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_step (
    .best_i        (best_q),
    .second_i      (second_q),
    .best_idx_i    (best_idx_q),
    .s_i           (scan_s_c),
    .ptr_i         (ptr_q),
    .best_nxt_c    (step_best_c),
    .second_nxt_c  (step_second_c),
    .best_idx_nxt_c(step_idx_c)
  );

  // Difference taken one bit wider, then truncated to the unsigned margin width.
  assign margin_c = DATA_WIDTH'((DATA_WIDTH+1)'(step_best_c) - (DATA_WIDTH+1)'(step_second_c));

  // Next-state and register updates; clear beats capture beats scan step.
  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    best_d        = best_q;
    second_d      = second_q;
    best_idx_d    = best_idx_q;
    ptr_d         = ptr_q;
    rd_data_d     = rd_data_q;
    rd_err_d      = rd_err_q;
    valid_d       = valid_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    margin_d      = margin_q;
    low_conf_d    = low_conf_q;

    if (rd_en) begin
      if (rd_idx > LAST_IDX) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else begin
        rd_data_d = snap_q[rd_idx];
        rd_err_d  = 1'b0;
      end
    end

    if (clear) begin
      state_d       = IDLE;
      valid_d       = 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) snap_d[i] = '0;
      best_d        = '0;
      second_d      = '0;
      best_idx_d    = '0;
      ptr_d         = '0;
      class_idx_d   = '0;
      class_score_d = '0;
      margin_d      = '0;
      low_conf_d    = 1'b0;
    end else if (capture) begin
      state_d    = SCAN;
      valid_d    = 1'b0;
      snap_d     = scores_in;
      best_d     = scores_in[0];
      best_idx_d = '0;
      second_d   = MIN_SCORE;
      ptr_d      = IDX_WIDTH'(1);
    end else if (state_q == SCAN) begin
      best_d     = step_best_c;
      second_d   = step_second_c;
      best_idx_d = step_idx_c;
      ptr_d      = ptr_q + IDX_WIDTH'(1);
      if (ptr_q == LAST_IDX) begin
        state_d       = DONE;
        valid_d       = 1'b1;
        class_idx_d   = step_idx_c;
        class_score_d = step_best_c;
        margin_d      = margin_c;
        low_conf_d    = (margin_c < THR);
      end
    end

    busy_d = (state_d == SCAN);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      for (int i = 0; i < NUM_CLASSES; i++) snap_q[i] <= '0;
      best_q        <= '0;
      second_q      <= '0;
      best_idx_q    <= '0;
      ptr_q         <= '0;
      rd_data_q     <= '0;
      rd_err_q      <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      margin_q      <= '0;
      low_conf_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      best_q        <= best_d;
      second_q      <= second_d;
      best_idx_q    <= best_idx_d;
      ptr_q         <= ptr_d;
      rd_data_q     <= rd_data_d;
      rd_err_q      <= rd_err_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      margin_q      <= margin_d;
      low_conf_q    <= low_conf_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_err       = rd_err_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign class_idx    = class_idx_q;
  assign class_score  = class_score_q;
  assign margin       = margin_q;
  assign low_conf     = low_conf_q;

endmodule

// File: tb/tb_dnn_result_unit.sv
// Self-checking bench for dnn_result_unit using an expected-result scoreboard.
module tb_dnn_result_unit;
  import dnn_result_pkg::*;

  localparam int NC = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          capture = 1'b0;
  logic          clear = 1'b0;
  logic          rd_en = 1'b0;
  logic [IW-1:0] rd_idx = '0;
  score_t        scores [NC];
  score_t        rd_data, class_score;
  logic          rd_err, busy, result_valid, low_conf;
  logic [IW-1:0] class_idx;
  logic [6:0]    margin;

  typedef struct {
    int idx;
    int score;
    int margin;
    bit low;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  dnn_result_unit dut (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .clear       (clear),
    .scores_in   (scores),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .busy        (busy),
    .result_valid(result_valid),
    .class_idx   (class_idx),
    .class_score (class_score),
    .margin      (margin),
    .low_conf    (low_conf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_vec(input int v[NC]);
    for (int i = 0; i < NC; i++) scores[i] = score_t'(v[i]);
  endtask

  // Reference: best = max with lowest index, second = max over all other entries.
  task automatic push_expected();
    exp_t e;
    int b = 0;
    int bs = int'(scores[0]);
    int s2 = -1000;
    for (int i = 1; i < NC; i++) if (int'(scores[i]) > bs) begin bs = int'(scores[i]); b = i; end
    for (int i = 0; i < NC; i++) if (i != b && int'(scores[i]) > s2) s2 = int'(scores[i]);
    e.idx = b;
    e.score = bs;
    e.margin = (bs - s2) & 127;
    e.low = (e.margin < 4);
    sb.push_back(e);
  endtask

  // Drives one capture pulse; returns at the negedge after the capture edge.
  task automatic start_capture();
    @(negedge clk);
    capture = 1'b1;
    push_expected();
    @(negedge clk);
    capture = 1'b0;
  endtask

  // Waits for result_valid, checks latency and compares against the scoreboard.
  task automatic wait_collect(input string tag);
    int n = 1;
    exp_t e;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_capture: got %b expected 1", tag, busy); end
    while (result_valid !== 1'b1 && n < 3 * NC) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != NC) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, n, NC); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b expected 0", tag, busy); end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (int'(class_idx) !== e.idx) begin errors++; $display("FAIL %s class_idx: got %0d expected %0d", tag, class_idx, e.idx); end
    checks++;
    if (int'(class_score) !== e.score) begin errors++; $display("FAIL %s class_score: got %0d expected %0d", tag, class_score, e.score); end
    checks++;
    if (int'(margin) !== e.margin) begin errors++; $display("FAIL %s margin: got %0d expected %0d", tag, margin, e.margin); end
    checks++;
    if (low_conf !== e.low) begin errors++; $display("FAIL %s low_conf: got %b expected %b", tag, low_conf, e.low); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_data, rd_err, busy, result_valid, class_idx, class_score, margin, low_conf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rd_data, rd_err, busy, result_valid, class_idx, class_score, margin, low_conf});
    end
    rst = 1'b1;
  endtask

  task automatic test_argmax();
    int v1[NC] = '{5, -3, 20, 9, 20, 1, -64, 0, 14, 2};
    int v2[NC] = '{-64, -64, -64, -64, -64, -64, -64, -64, -64, -64};
    int v3[NC] = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 63};
    int v4[NC] = '{63, -64, -64, -64, -64, -64, -64, -64, -64, -64};
    int v5[NC] = '{-10, 3, -10, -10, -10, 7, -10, -10, -10, -10};
    int v6[NC] = '{-10, 3, -10, -10, -10, 6, -10, -10, -10, -10};
    load_vec(v1); start_capture(); wait_collect("tie_top");
    load_vec(v2); start_capture(); wait_collect("all_min");
    load_vec(v3); start_capture(); wait_collect("last_wins");
    load_vec(v4); start_capture(); wait_collect("max_margin");
    load_vec(v5); start_capture(); wait_collect("margin_at_thr");
    load_vec(v6); start_capture(); wait_collect("margin_below_thr");
  endtask

  task automatic test_read();
    int v1[NC] = '{5, -3, 20, 9, 20, 1, -64, 0, 14, 2};
    load_vec(v1); start_capture(); wait_collect("read_setup");
    for (int i = 0; i < NC; i++) begin
      rd_en = 1'b1;
      rd_idx = IW'(i);
      @(negedge clk);
      checks++;
      if (int'(rd_data) !== v1[i] || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL read_idx%0d: got %0d/%b expected %0d/0", i, rd_data, rd_err, v1[i]);
      end
    end
    rd_idx = IW'(12);
    @(negedge clk);
    checks++;
    if (rd_data !== '0 || rd_err !== 1'b1) begin errors++; $display("FAIL read_oob: got %0d/%b expected 0/1", rd_data, rd_err); end
    rd_en = 1'b0;
    rd_idx = IW'(3);
    repeat (2) @(negedge clk);
    checks++;
    if (rd_data !== '0 || rd_err !== 1'b1) begin errors++; $display("FAIL read_hold: got %0d/%b expected 0/1", rd_data, rd_err); end
  endtask

  task automatic test_back_to_back();
    int va[NC] = '{33, 1, 2, 3, 4, 5, 6, 7, 8, -9};
    int vb[NC] = '{0, 0, 0, 0, 0, 0, 0, 40, 0, 0};
    load_vec(va);
    @(negedge clk);
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL scan_a_state: got valid=%b busy=%b expected 0/1", result_valid, busy);
      end
    end
    // Read issued with the restart capture must see the old snapshot.
    rd_en = 1'b1;
    rd_idx = '0;
    load_vec(vb);
    start_capture();
    rd_en = 1'b0;
    checks++;
    if (int'(rd_data) !== 33) begin errors++; $display("FAIL read_with_capture: got %0d expected 33", rd_data); end
    wait_collect("restart_b");
  endtask

  task automatic test_clear_capture();
    int v1[NC] = '{5, -3, 20, 9, 20, 1, -64, 0, 14, 2};
    int seen = 0;
    load_vec(v1);
    @(negedge clk);
    clear = 1'b1;
    capture = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    capture = 1'b0;
    checks++;
    if ({busy, result_valid, class_idx, class_score, margin, low_conf} !== '0) begin
      errors++;
      $display("FAIL clear_outputs: got %h expected 0", {busy, result_valid, class_idx, class_score, margin, low_conf});
    end
    repeat (2 * NC) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL clear_stays_idle: got %0d active cycles expected 0", seen); end
    rd_en = 1'b1;
    rd_idx = IW'(2);
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rd_data !== '0 || rd_err !== 1'b0) begin errors++; $display("FAIL clear_snapshot: got %0d/%b expected 0/0", rd_data, rd_err); end
  endtask

  task automatic test_async_reset();
    int v1[NC] = '{5, -3, 20, 9, 20, 1, -64, 0, 14, 2};
    int vc[NC] = '{-5, 17, 3, 3, 3, 3, 3, 3, 3, 3};
    int v3[NC] = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 63};
    load_vec(v1); start_capture(); wait_collect("pre_reset");
    load_vec(vc);
    @(negedge clk);
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    rd_en = 1'b1;
    rd_idx = IW'(1);
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (int'(rd_data) !== 17) begin errors++; $display("FAIL read_during_scan: got %0d expected 17", rd_data); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({rd_data, rd_err, busy, result_valid, class_idx, class_score, margin, low_conf} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h expected 0",
               {rd_data, rd_err, busy, result_valid, class_idx, class_score, margin, low_conf});
    end
    @(negedge clk);
    rst = 1'b1;
    load_vec(v3); start_capture(); wait_collect("after_reset");
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) scores[i] = '0;
    test_reset();
    test_argmax();
    test_read();
    test_back_to_back();
    test_clear_capture();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dnn_result_unit.md
Name: dnn_result_unit

Overview:
- Output stage placed after the dnn_relu_fix7 inference core. It replaces the combinational class-output mux.
- On a capture pulse it snapshots the NUM_CLASSES class scores.
- It then runs a sequential signed argmax scan, one class per cycle, and reports the winning class, its score, the winner-to-runner-up margin and a low-confidence flag.
- It also provides a registered indexed read port into the snapshot, with out-of-range detection.

Parameters:
DATA_WIDTH, 7, signed score width (matches the fix7 datapath)
NUM_CLASSES, 10, number of class scores; must be >= 2
IDX_WIDTH, 4, index width; must satisfy 2**IDX_WIDTH >= NUM_CLASSES
MARGIN_THR, 4, unsigned threshold; low_conf is set when margin < MARGIN_THR

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset
capture  in  1  single-cycle pulse driven from the core's done; snapshots scores_in
clear  in  1  synchronous clear to IDLE
scores_in  in  NUM_CLASSES x DATA_WIDTH signed (unpacked array)  class scores from the core
rd_en  in  1  read request
rd_idx  in  IDX_WIDTH  read index
rd_data  out  DATA_WIDTH signed  registered snapshot[rd_idx]
rd_err  out  1  registered; rd_idx >= NUM_CLASSES on the last read
busy  out  1  high while in SCAN
result_valid  out  1  argmax results are valid
class_idx  out  IDX_WIDTH  winning class
class_score  out  DATA_WIDTH signed  winning score
margin  out  DATA_WIDTH unsigned  class_score minus second-best score
low_conf  out  1  margin < MARGIN_THR

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - Snapshot, best, second and index registers clear to 0.
  - Every output goes to 0.
  - Reset applies immediately, including mid-scan.
- FSM states: IDLE, SCAN, DONE.
- Priority at each clock edge: clear > capture > scan step.
- clear: go to IDLE, result_valid=0, snapshot zeroed, result registers zeroed.
- capture, accepted in any state including SCAN:
  - Load snapshot <= scores_in.
  - best <= scores_in[0], best_idx <= 0, second <= -2**(DATA_WIDTH-1), ptr <= 1.
  - State <= SCAN, result_valid <= 0.
  - Capture during SCAN restarts the scan on the new data; the old scan is discarded.
- SCAN step (one per cycle, s = snapshot[ptr]):
  - If s > best (signed): second <= best, best <= s, best_idx <= ptr.
  - Else if s > second: second <= s.
  - Ties never replace best, so the lowest index wins. An equal value updates second, so a tie gives margin 0.
  - ptr increments each step. On the step with ptr == NUM_CLASSES-1, go to DONE and register the outputs.
- Latency: with capture sampled at edge T, result_valid is high after edge T+NUM_CLASSES-1 (9 cycles for the defaults). busy is high from T to T+NUM_CLASSES-2 inclusive.
- DONE: outputs hold until the next capture, clear or reset.
- Output arithmetic:
  - margin = best - second, computed in DATA_WIDTH+1 bits, then truncated to DATA_WIDTH unsigned. The result always lies in 0..2**DATA_WIDTH-1.
  - low_conf is registered together with margin.
- Read port:
  - On rd_en at edge T, rd_data/rd_err update at edge T (1-cycle latency).
  - In range: rd_data = snapshot[rd_idx], rd_err = 0.
  - rd_idx >= NUM_CLASSES: rd_data = 0, rd_err = 1.
  - When rd_en=0, rd_data/rd_err hold.
  - Reads are legal in any state and always return the snapshot, including during SCAN.
  - A read in the same cycle as capture returns the pre-capture snapshot.

Decomposition:
- Package dnn_result_pkg holds:
  - state_t enum {IDLE, SCAN, DONE}
  - score_t typedef (signed DATA_WIDTH)
  - SCORE_MIN constant
  - clog2-based index width helper
- Sub-module dnn_argmax_step: purely combinational. Inputs: best, second, best_idx, s, ptr. Outputs: next best, next second, next best_idx. The top level holds the FSM, snapshot registers and read port.

Test Plan:
1. Defaults; capture with scores[0..9] = 5,-3,20,9,20,1,-64,0,14,2 -> 9 cycles later result_valid=1, class_idx=2, class_score=20, margin=0, low_conf=1.
2. All scores = -64 -> class_idx=0, class_score=-64, margin=0, low_conf=1. Scores all 10 except [9]=63 -> class_idx=9, class_score=63, margin=53, low_conf=0.
3. After capture of test 1: rd_idx=3 -> rd_data=9, rd_err=0 next cycle. rd_idx=12 -> rd_data=0, rd_err=1. rd_en=0 -> both hold.
4. Capture vector A, then capture vector B (B[7]=40, rest 0) on the 4th SCAN cycle -> no result_valid for A; result_valid exactly 9 cycles after the B capture, with class_idx=7, margin=40.
5. clear and capture asserted in the same cycle -> state IDLE, result_valid=0, busy=0, rd_data of index 2 reads 0.
6. rst driven low mid-SCAN between clock edges -> all outputs 0 without waiting for a clock edge. After release, a fresh capture completes normally in 9 cycles.
